// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard, drain/UART-rewrite and interrupt controller.
// Every registered output updates on the falling clock edge.
module hazard_ctrl_unit #(
    parameter int unsigned     STAGE_CNT  = 5,
    parameter int unsigned     IRQ_CNT    = 4,
    parameter int unsigned     REG_ADDR_W = 5,
    parameter int unsigned     PC_W       = 32,
    parameter logic [PC_W-1:0] PC_MAX     = PC_W'(32'h0000_3FFF),
    localparam int unsigned    IRQ_ID_W   = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    reg_1_valid,
    input  logic                    reg_2_valid,
    input  logic                    branch_instruction,
    input  logic                    ex_mem_read_enable,
    input  logic                    ex_reg_write_enable,
    input  logic                    ex_no_op,
    input  logic                    mem_reg_write_enable,
    input  logic                    mem_no_op,
    input  logic [REG_ADDR_W-1:0]   id_reg_1_idx,
    input  logic [REG_ADDR_W-1:0]   id_reg_2_idx,
    input  logic [REG_ADDR_W-1:0]   ex_reg_dest_idx,
    input  logic [REG_ADDR_W-1:0]   mem_reg_dest_idx,
    input  logic [PC_W-1:0]         pc_next,
    input  logic                    cpu_pause,
    input  logic                    cpu_resume,
    input  logic                    uart_complete,
    input  logic [IRQ_CNT-1:0]      irq_req,
    input  logic [IRQ_CNT-1:0]      irq_mask,
    input  logic [IRQ_CNT-1:0]      irq_done,
    output logic                    uart_disable,
    output logic                    pc_reset,
    output logic [2*STAGE_CNT-1:0]  hazard_control,
    output logic [IRQ_CNT-1:0]      irq_ack,
    output logic [IRQ_ID_W-1:0]     irq_id,
    output logic [2:0]              cpu_state,
    output logic [2:0]              issue_type,
    output logic [15:0]             stall_count
);

    localparam int unsigned HC_W  = 2 * STAGE_CNT;
    localparam int unsigned CNT_W = $clog2(STAGE_CNT);

    localparam logic [HC_W-1:0]  HC_NORMAL   = '0;
    localparam logic [HC_W-1:0]  HC_ALL_HOLD = {STAGE_CNT{2'b01}};
    localparam logic [HC_W-1:0]  HC_DATA     = HC_W'(6'b10_01_01);
    localparam logic [HC_W-1:0]  HC_IF_NOOP  = HC_W'(2'b10);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(STAGE_CNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXECUTE   = 3'd1,
        ST_HAZARD    = 3'd2,
        ST_INTERRUPT = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        IS_NONE  = 3'd0,
        IS_DATA  = 3'd1,
        IS_UART  = 3'd2,
        IS_PAUSE = 3'd3,
        IS_IRQ   = 3'd4
    } issue_t;

    state_t               r_state, w_state_nxt;
    issue_t               r_issue, w_issue_nxt;
    logic [HC_W-1:0]      r_hc, w_hc_nxt;
    logic                 r_uart_dis, w_uart_dis_nxt;
    logic                 r_pc_reset, w_pc_reset_nxt;
    logic [IRQ_CNT-1:0]   r_ack, w_ack_nxt;
    logic [IRQ_ID_W-1:0]  r_id, w_id_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [15:0]          r_stall, w_stall_nxt;

    logic                 w_ex_conflict, w_mem_conflict;
    logic                 w_data_hazard, w_uart_hazard;
    logic                 w_irq_valid;
    logic [IRQ_ID_W-1:0]  w_irq_cand;

    assign w_ex_conflict  = ex_reg_write_enable & ~ex_no_op &
                            ((reg_1_valid & (id_reg_1_idx == ex_reg_dest_idx)) |
                             (reg_2_valid & (id_reg_2_idx == ex_reg_dest_idx)));
    assign w_mem_conflict = mem_reg_write_enable & ~mem_no_op &
                            ((reg_1_valid & (id_reg_1_idx == mem_reg_dest_idx)) |
                             (reg_2_valid & (id_reg_2_idx == mem_reg_dest_idx)));
    assign w_data_hazard  = (branch_instruction & (w_ex_conflict | w_mem_conflict)) |
                            (ex_mem_read_enable & w_ex_conflict);
    assign w_uart_hazard  = pc_next > PC_MAX;

    // Lowest-index enabled request wins; scanning downward lets it overwrite.
    always_comb begin
        w_irq_valid = 1'b0;
        w_irq_cand  = '0;
        for (int i = int'(IRQ_CNT) - 1; i >= 0; i--) begin
            if (irq_req[i] & irq_mask[i]) begin
                w_irq_valid = 1'b1;
                w_irq_cand  = IRQ_ID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_issue_nxt    = r_issue;
        w_hc_nxt       = r_hc;
        w_uart_dis_nxt = r_uart_dis;
        w_pc_reset_nxt = 1'b0;
        w_ack_nxt      = r_ack;
        w_id_nxt       = r_id;
        w_cnt_nxt      = r_cnt;
        w_stall_nxt    = r_stall;

        if ((r_state inside {ST_DRAIN, ST_HAZARD, ST_INTERRUPT}) && (r_stall != 16'hFFFF)) begin
            w_stall_nxt = r_stall + 16'd1;
        end

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (w_data_hazard) begin
                    w_state_nxt = ST_HAZARD;
                    w_issue_nxt = IS_DATA;
                    w_hc_nxt    = HC_DATA;
                end else if (cpu_pause || w_uart_hazard) begin
                    w_state_nxt = ST_DRAIN;
                    w_issue_nxt = cpu_pause ? IS_PAUSE : IS_UART;
                    w_hc_nxt    = HC_IF_NOOP;
                    w_cnt_nxt   = DRAIN_LOAD;
                end else if (w_irq_valid) begin
                    w_state_nxt = ST_INTERRUPT;
                    w_issue_nxt = IS_IRQ;
                    w_hc_nxt    = HC_ALL_HOLD;
                    w_id_nxt    = w_irq_cand;
                    w_ack_nxt   = IRQ_CNT'(1) << w_irq_cand;
                end
            end
            ST_DRAIN: begin
                if (cpu_pause && (r_issue == IS_UART)) begin
                    w_issue_nxt = IS_PAUSE;
                end
                // Leaving on the last count keeps the drain exactly STAGE_CNT-1 cycles long.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt    = ST_HAZARD;
                    w_cnt_nxt      = '0;
                    w_uart_dis_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HAZARD: begin
                if (r_issue == IS_DATA) begin
                    if (!w_data_hazard) begin
                        w_state_nxt = ST_EXECUTE;
                        w_issue_nxt = IS_NONE;
                        w_hc_nxt    = HC_NORMAL;
                    end
                end else if (((r_issue == IS_UART) && uart_complete) ||
                             ((r_issue == IS_PAUSE) && cpu_resume && uart_complete)) begin
                    w_state_nxt    = ST_EXECUTE;
                    w_issue_nxt    = IS_NONE;
                    w_hc_nxt       = HC_NORMAL;
                    w_uart_dis_nxt = 1'b1;
                    w_pc_reset_nxt = 1'b1;
                end else if (cpu_pause && (r_issue == IS_UART)) begin
                    w_issue_nxt = IS_PAUSE;
                end
            end
            ST_INTERRUPT: begin
                if (irq_done[r_id]) begin
                    w_state_nxt = ST_EXECUTE;
                    w_issue_nxt = IS_NONE;
                    w_hc_nxt    = HC_NORMAL;
                    w_ack_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_issue    <= IS_NONE;
            r_hc       <= HC_NORMAL;
            r_uart_dis <= 1'b1;
            r_pc_reset <= 1'b0;
            r_ack      <= '0;
            r_id       <= '0;
            r_cnt      <= '0;
            r_stall    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_issue    <= w_issue_nxt;
            r_hc       <= w_hc_nxt;
            r_uart_dis <= w_uart_dis_nxt;
            r_pc_reset <= w_pc_reset_nxt;
            r_ack      <= w_ack_nxt;
            r_id       <= w_id_nxt;
            r_cnt      <= w_cnt_nxt;
            r_stall    <= w_stall_nxt;
        end
    end

    assign cpu_state      = r_state;
    assign issue_type     = r_issue;
    assign hazard_control = r_hc;
    assign uart_disable   = r_uart_dis;
    assign pc_reset       = r_pc_reset;
    assign irq_ack        = r_ack;
    assign irq_id         = r_id;
    assign stall_count    = r_stall;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed vectors push expected
// snapshots, a monitor pops and compares one per falling-edge update.
module tb_hazard_ctrl_unit;

    localparam logic [2:0] S_IDLE = 3'd0, S_EXE = 3'd1, S_HAZ = 3'd2, S_INT = 3'd3, S_DRN = 3'd4;
    localparam logic [2:0] I_NONE = 3'd0, I_DATA = 3'd1, I_UART = 3'd2, I_PAUSE = 3'd3, I_IRQ = 3'd4;
    localparam logic [9:0] HC_N = 10'b00_00_00_00_00;
    localparam logic [9:0] HC_D = 10'b00_00_10_01_01;
    localparam logic [9:0] HC_F = 10'b00_00_00_00_10;
    localparam logic [9:0] HC_H = 10'b01_01_01_01_01;
    localparam logic [31:0] PC_OVER = 32'h0000_3FFF + 32'd4;

    typedef struct packed {
        logic [2:0]  st;
        logic [2:0]  it;
        logic [9:0]  hc;
        logic        ud;
        logic        pr;
        logic [3:0]  ack;
        logic [1:0]  id;
        logic [15:0] sc;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_1_valid, reg_2_valid, branch_instruction;
    logic        ex_mem_read_enable, ex_reg_write_enable, ex_no_op;
    logic        mem_reg_write_enable, mem_no_op;
    logic [4:0]  id_reg_1_idx, id_reg_2_idx, ex_reg_dest_idx, mem_reg_dest_idx;
    logic [31:0] pc_next;
    logic        cpu_pause, cpu_resume, uart_complete;
    logic [3:0]  irq_req, irq_mask, irq_done;
    logic        uart_disable, pc_reset;
    logic [9:0]  hazard_control;
    logic [3:0]  irq_ack;
    logic [1:0]  irq_id;
    logic [2:0]  cpu_state, issue_type;
    logic [15:0] stall_count;

    snap_t q_exp[$];
    string q_name[$];
    int    n_checks = 0;
    int    n_err    = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n),
        .reg_1_valid(reg_1_valid), .reg_2_valid(reg_2_valid),
        .branch_instruction(branch_instruction),
        .ex_mem_read_enable(ex_mem_read_enable), .ex_reg_write_enable(ex_reg_write_enable),
        .ex_no_op(ex_no_op),
        .mem_reg_write_enable(mem_reg_write_enable), .mem_no_op(mem_no_op),
        .id_reg_1_idx(id_reg_1_idx), .id_reg_2_idx(id_reg_2_idx),
        .ex_reg_dest_idx(ex_reg_dest_idx), .mem_reg_dest_idx(mem_reg_dest_idx),
        .pc_next(pc_next),
        .cpu_pause(cpu_pause), .cpu_resume(cpu_resume), .uart_complete(uart_complete),
        .irq_req(irq_req), .irq_mask(irq_mask), .irq_done(irq_done),
        .uart_disable(uart_disable), .pc_reset(pc_reset),
        .hazard_control(hazard_control),
        .irq_ack(irq_ack), .irq_id(irq_id),
        .cpu_state(cpu_state), .issue_type(issue_type), .stall_count(stall_count)
    );

    // Monitor: outputs settle on the falling edge, so sample just after the rising edge.
    initial begin
        snap_t e, a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                a  = {cpu_state, issue_type, hazard_control, uart_disable, pc_reset,
                      irq_ack, irq_id, stall_count};
                n_checks++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL %s: got st=%0d it=%0d hc=%b ud=%b pr=%b ack=%b id=%0d sc=%0d | want st=%0d it=%0d hc=%b ud=%b pr=%b ack=%b id=%0d sc=%0d",
                             nm, a.st, a.it, a.hc, a.ud, a.pr, a.ack, a.id, a.sc,
                             e.st, e.it, e.hc, e.ud, e.pr, e.ack, e.id, e.sc);
                end
            end
        end
    end

    // Inputs are already set for the coming falling edge; queue its expected result.
    task automatic cyc(input string nm, input logic [2:0] st, input logic [2:0] it,
                       input logic [9:0] hc, input logic ud, input logic pr,
                       input logic [3:0] ack, input logic [1:0] id, input logic [15:0] sc);
        snap_t e;
        e = {st, it, hc, ud, pr, ack, id, sc};
        q_exp.push_back(e);
        q_name.push_back(nm);
        @(posedge clk);
        #2;
        cpu_pause     = 1'b0;
        cpu_resume    = 1'b0;
        uart_complete = 1'b0;
        irq_done      = 4'b0000;
    endtask

    task automatic clear_data;
        reg_1_valid = 0; reg_2_valid = 0; branch_instruction = 0;
        ex_mem_read_enable = 0; ex_reg_write_enable = 0; ex_no_op = 0;
        mem_reg_write_enable = 0; mem_no_op = 0;
        id_reg_1_idx = 0; id_reg_2_idx = 0; ex_reg_dest_idx = 0; mem_reg_dest_idx = 0;
    endtask

    task automatic set_load_use;
        ex_mem_read_enable = 1; ex_reg_write_enable = 1; ex_reg_dest_idx = 5'd5;
        id_reg_1_idx = 5'd5; reg_1_valid = 1;
    endtask

    initial begin
        rst_n = 0;
        clear_data();
        pc_next = 32'h0000_0100;
        cpu_pause = 0; cpu_resume = 0; uart_complete = 0;
        irq_req = 0; irq_mask = 0; irq_done = 0;
        @(posedge clk);
        #2;

        cyc("reset",       S_IDLE, I_NONE, HC_N, 1, 0, 4'b0000, 0, 0);
        rst_n = 1;
        cyc("idle_to_exe", S_EXE,  I_NONE, HC_N, 1, 0, 4'b0000, 0, 0);

        // Load-use on r5
        set_load_use();
        cyc("ld_haz",      S_HAZ,  I_DATA, HC_D, 1, 0, 4'b0000, 0, 0);
        clear_data();
        cyc("ld_exit",     S_EXE,  I_NONE, HC_N, 1, 0, 4'b0000, 0, 1);

        // Branch vs MEM write, first with MEM bubbled (no hazard), then live
        branch_instruction = 1; mem_reg_write_enable = 1; mem_reg_dest_idx = 5'd7;
        id_reg_2_idx = 5'd7; reg_2_valid = 1; mem_no_op = 1;
        cyc("br_mem_noop", S_EXE,  I_NONE, HC_N, 1, 0, 4'b0000, 0, 1);
        mem_no_op = 0;
        cyc("br_haz",      S_HAZ,  I_DATA, HC_D, 1, 0, 4'b0000, 0, 1);
        cyc("br_hold",     S_HAZ,  I_DATA, HC_D, 1, 0, 4'b0000, 0, 2);
        clear_data();
        cyc("br_exit",     S_EXE,  I_NONE, HC_N, 1, 0, 4'b0000, 0, 3);

        // UART rewrite: 4 drain cycles, data hazard ignored mid-drain
        pc_next = PC_OVER;
        cyc("u_drain0",    S_DRN,  I_UART, HC_F, 1, 0, 4'b0000, 0, 3);
        pc_next = 32'h0000_0100;
        cyc("u_drain1",    S_DRN,  I_UART, HC_F, 1, 0, 4'b0000, 0, 4);
        set_load_use();
        cyc("u_drain2",    S_DRN,  I_UART, HC_F, 1, 0, 4'b0000, 0, 5);
        clear_data();
        cyc("u_drain3",    S_DRN,  I_UART, HC_F, 1, 0, 4'b0000, 0, 6);
        cyc("u_haz",       S_HAZ,  I_UART, HC_F, 0, 0, 4'b0000, 0, 7);
        cyc("u_wait",      S_HAZ,  I_UART, HC_F, 0, 0, 4'b0000, 0, 8);
        uart_complete = 1;
        cyc("u_done",      S_EXE,  I_NONE, HC_N, 1, 1, 4'b0000, 0, 9);
        cyc("u_pcrst_off", S_EXE,  I_NONE, HC_N, 1, 0, 4'b0000, 0, 9);

        // UART rewrite upgraded to pause during drain
        pc_next = PC_OVER;
        cyc("p_drain0",    S_DRN,  I_UART,  HC_F, 1, 0, 4'b0000, 0, 9);
        pc_next = 32'h0000_0100;
        cyc("p_drain1",    S_DRN,  I_UART,  HC_F, 1, 0, 4'b0000, 0, 10);
        cpu_pause = 1;
        cyc("p_upgrade",   S_DRN,  I_PAUSE, HC_F, 1, 0, 4'b0000, 0, 11);
        cyc("p_drain3",    S_DRN,  I_PAUSE, HC_F, 1, 0, 4'b0000, 0, 12);
        cyc("p_haz",       S_HAZ,  I_PAUSE, HC_F, 0, 0, 4'b0000, 0, 13);
        uart_complete = 1;
        cyc("p_uc_only",   S_HAZ,  I_PAUSE, HC_F, 0, 0, 4'b0000, 0, 14);
        cpu_resume = 1;
        cyc("p_res_only",  S_HAZ,  I_PAUSE, HC_F, 0, 0, 4'b0000, 0, 15);
        cpu_resume = 1; uart_complete = 1;
        cyc("p_both",      S_EXE,  I_NONE,  HC_N, 1, 1, 4'b0000, 0, 16);
        cyc("p_after",     S_EXE,  I_NONE,  HC_N, 1, 0, 4'b0000, 0, 16);

        // Data hazard beats a same-cycle pause, which is dropped
        set_load_use();
        cpu_pause = 1;
        cyc("prio_data",   S_HAZ,  I_DATA, HC_D, 1, 0, 4'b0000, 0, 16);
        clear_data();
        cyc("prio_exit",   S_EXE,  I_NONE, HC_N, 1, 0, 4'b0000, 0, 17);
        cyc("prio_nolatch",S_EXE,  I_NONE, HC_N, 1, 0, 4'b0000, 0, 17);

        // Masked interrupt selection and done handling
        irq_req = 4'b1010; irq_mask = 4'b1000;
        cyc("irq_enter",   S_INT,  I_IRQ,  HC_H, 1, 0, 4'b1000, 3, 17);
        irq_done = 4'b0010;
        cyc("irq_wrongdn", S_INT,  I_IRQ,  HC_H, 1, 0, 4'b1000, 3, 18);
        irq_req = 4'b0000; irq_mask = 4'b0000;
        cyc("irq_reqdrop", S_INT,  I_IRQ,  HC_H, 1, 0, 4'b1000, 3, 19);
        irq_done = 4'b1000;
        cyc("irq_done",    S_EXE,  I_NONE, HC_N, 1, 0, 4'b0000, 3, 20);

        // Reset in the middle of an interrupt
        irq_req = 4'b0110; irq_mask = 4'b0111;
        cyc("irq2_enter",  S_INT,  I_IRQ,  HC_H, 1, 0, 4'b0010, 1, 20);
        cyc("irq2_hold",   S_INT,  I_IRQ,  HC_H, 1, 0, 4'b0010, 1, 21);
        rst_n = 0;
        cyc("rst_in_irq",  S_IDLE, I_NONE, HC_N, 1, 0, 4'b0000, 0, 0);
        rst_n = 1; irq_req = 4'b0000; irq_mask = 4'b0000;
        cyc("rst_release", S_EXE,  I_NONE, HC_N, 1, 0, 4'b0000, 0, 0);

        for (int k = 0; k < 5 && q_exp.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (q_exp.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_queue: %0d expectations left, want 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter STAGE_CNT, default 5: number of pipeline stage registers controlled (minimum 3).
REQ-002 SHALL have parameter IRQ_CNT, default 4: number of interrupt sources (minimum 1).
REQ-003 SHALL have parameter REG_ADDR_W, default 5: register index width.
REQ-004 SHALL have parameter PC_W, default 32, and parameter PC_MAX, default 32'h0000_3FFF: PC width and last valid instruction address.
REQ-005 SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  synchronous, active-low reset.
- reg_1_valid, reg_2_valid  in  1  ID stage source register is used.
- branch_instruction  in  1  ID stage holds a branch.
- ex_mem_read_enable, ex_reg_write_enable, ex_no_op  in  1  EX stage load, write-back and bubble flags.
- mem_reg_write_enable, mem_no_op  in  1  MEM stage write-back and bubble flags.
- id_reg_1_idx, id_reg_2_idx, ex_reg_dest_idx, mem_reg_dest_idx  in  REG_ADDR_W  register indices.
- pc_next  in  PC_W  next fetch address.
- cpu_pause, cpu_resume  in  1  single-cycle user pause and resume pulses.
- uart_complete  in  1  UART rewrite done.
- irq_req  in  IRQ_CNT  level interrupt requests.
- irq_mask  in  IRQ_CNT  1 = source enabled.
- irq_done  in  IRQ_CNT  service-complete pulse per source.
- uart_disable  out  1  0 = UART rewrite mode.
- pc_reset  out  1  one-cycle PC clear.
- hazard_control  out  2*STAGE_CNT  2 bits per stage; stage 0 = IF in bits [1:0]; 00 NORMAL, 01 HOLD, 10 NO_OP.
- irq_ack  out  IRQ_CNT  one-hot grant.
- irq_id  out  max(1,$clog2(IRQ_CNT))  index of the granted source.
- cpu_state  out  3  0 IDLE, 1 EXECUTE, 2 HAZARD, 3 INTERRUPT, 4 DRAIN.
- issue_type  out  3  0 NONE, 1 DATA, 2 UART, 3 PAUSE, 4 IRQ.
- stall_count  out  16  count of non-EXECUTE cycles.

Function
REQ-006 SHALL update all registered outputs on the falling edge of clk.
REQ-007 SHALL compute ex_conflict = ex_reg_write_enable & ~ex_no_op & ((reg_1_valid & id_reg_1_idx==ex_reg_dest_idx) | (reg_2_valid & id_reg_2_idx==ex_reg_dest_idx)); mem_conflict is identical using the MEM stage signals.
REQ-008 SHALL define data_hazard = (branch_instruction & (ex_conflict|mem_conflict)) | (ex_mem_read_enable & ex_conflict), and uart_hazard = pc_next > PC_MAX (unsigned).
REQ-009 SHALL define the irq candidate as the lowest index i with irq_req[i] & irq_mask[i].
REQ-010 SHALL go from IDLE to EXECUTE unconditionally one cycle after reset.
REQ-011 In EXECUTE, SHALL evaluate events in fixed priority data_hazard > cpu_pause > uart_hazard > irq; only the highest-priority event is acted on.
REQ-012 On data_hazard, SHALL enter HAZARD/DATA with IF=HOLD, ID=HOLD, EX=NO_OP and all other stages NORMAL; SHALL return to EXECUTE with all stages NORMAL on the first cycle data_hazard is 0.
REQ-013 On pause or uart_hazard, SHALL enter DRAIN with issue_type PAUSE or UART, IF=NO_OP, and load a drain counter with STAGE_CNT-1.
REQ-014 In DRAIN, SHALL decrement the counter each cycle; at zero it SHALL enter HAZARD and drive uart_disable=0; data hazards and irqs SHALL be ignored while in DRAIN.
REQ-015 In HAZARD/UART, SHALL exit on uart_complete; in HAZARD/PAUSE, SHALL exit on cpu_resume & uart_complete in the same cycle.
REQ-016 On exit from HAZARD/UART or HAZARD/PAUSE, SHALL set uart_disable=1, IF=NORMAL, pc_reset=1 for exactly one cycle, and go to EXECUTE.
REQ-017 A cpu_pause pulse during DRAIN or HAZARD with issue_type UART SHALL upgrade issue_type to PAUSE without restarting the drain counter.
REQ-018 On irq, SHALL enter INTERRUPT/IRQ, latch irq_id, drive irq_ack one-hot at irq_id, and set all stages HOLD.
REQ-019 In INTERRUPT, SHALL ignore irq_req changes, masking and other irq_done bits; irq_done[irq_id] SHALL clear irq_ack, set all stages NORMAL and return to EXECUTE.
REQ-020 SHALL increment stall_count every cycle cpu_state is DRAIN, HAZARD or INTERRUPT, saturating at 16'hFFFF.

Reset
REQ-021 rst_n=0 sampled at a falling clk edge SHALL force: cpu_state IDLE, issue_type NONE, all stages NORMAL, uart_disable 1, pc_reset 0, irq_ack 0, irq_id 0, stall_count 0, drain counter 0.
REQ-022 Reset SHALL override any state mid-operation, including DRAIN and INTERRUPT, within the same edge.

Verification
REQ-023 Load to r5 in EX, ID uses r5 as reg_1 -> one HAZARD/DATA cycle with hazard_control=10'b00_00_10_01_01, then EXECUTE; stall_count=1.
REQ-024 pc_next=PC_MAX+4 -> DRAIN for 4 cycles with IF=NO_OP, then HAZARD with uart_disable=0; uart_complete -> pc_reset high for one cycle, uart_disable=1, EXECUTE.
REQ-025 pc_next=PC_MAX+4, cpu_pause at drain cycle 2 -> issue_type=PAUSE; uart_complete alone holds HAZARD; uart_complete & cpu_resume -> EXECUTE.
REQ-026 irq_req=4'b1010 with irq_mask=4'b1000 -> irq_id=3, irq_ack=4'b1000, all stages HOLD; irq_done=4'b0010 -> no change; irq_done=4'b1000 -> EXECUTE.
REQ-027 data_hazard and cpu_pause asserted in the same cycle -> HAZARD/DATA is taken first, and the pause is not latched.
REQ-028 rst_n low during INTERRUPT -> next falling edge gives all outputs at their reset values, IDLE then EXECUTE.
